// File: rtl/imem_loader.sv
// Host byte-stream to IMEM writer: packs bytes little-endian into 32-bit words,
// writes them from word address 0 upward, and holds the CPU until the image is complete.
module imem_loader #(
  parameter int MEM_WIDTH_LENGTH = 32,
  parameter int ADDR_WIDTH       = 18,
  parameter int MEM_DEPTH        = 1 << 18
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  input  logic                        byte_last,
  output logic                        byte_ready,
  output logic                        we,
  output logic [ADDR_WIDTH-1:0]       waddr,
  output logic [MEM_WIDTH_LENGTH-1:0] wdata,
  output logic [ADDR_WIDTH:0]         word_count,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic                        cpu_hold
);

  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                        state_q;
  logic [1:0]                    byte_idx_q;
  logic [MEM_WIDTH_LENGTH-1:0]   asm_q;
  logic [MEM_WIDTH_LENGTH-1:0]   word_s;
  logic                          accept_s;

  assign byte_ready = (state_q == S_LOAD);
  assign accept_s   = byte_valid & byte_ready;

  // Assembly buffer with the incoming byte merged into its lane; lanes above stay zero.
  always_comb begin
    word_s = asm_q;
    case (byte_idx_q)
      2'd0:    word_s[7:0]   = byte_in;
      2'd1:    word_s[15:8]  = byte_in;
      2'd2:    word_s[23:16] = byte_in;
      2'd3:    word_s[31:24] = byte_in;
      default: word_s        = asm_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_idx_q <= 2'd0;
      asm_q      <= '0;
      we         <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      word_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      we <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state_q    <= S_LOAD;
            byte_idx_q <= 2'd0;
            asm_q      <= '0;
            word_count <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            cpu_hold   <= 1'b1;
          end else begin
            state_q <= state_q;
          end
        end
        S_LOAD: begin
          if (accept_s) begin
            // Overflow wins over byte_last: the byte is dropped and nothing is written.
            if (word_count == DEPTH_C) begin
              state_q  <= S_ERR;
              busy     <= 1'b0;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end else if (byte_last || (byte_idx_q == 2'd3)) begin
              we         <= 1'b1;
              waddr      <= word_count[ADDR_WIDTH-1:0];
              wdata      <= word_s;
              word_count <= word_count + ONE_C;
              asm_q      <= '0;
              byte_idx_q <= 2'd0;
              if (byte_last) begin
                state_q <= S_FLUSH;
              end else begin
                state_q <= S_LOAD;
              end
            end else begin
              asm_q      <= word_s;
              byte_idx_q <= byte_idx_q + 2'd1;
            end
          end else begin
            state_q <= S_LOAD;
          end
        end
        S_FLUSH: begin
          state_q  <= S_DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          cpu_hold <= 1'b0;
        end
        default: begin
          state_q    <= S_IDLE;
          byte_idx_q <= 2'd0;
          asm_q      <= '0;
          busy       <= 1'b0;
          done       <= 1'b0;
          err        <= 1'b0;
          cpu_hold   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: a cycle table for the main flows plus
// hand-written reset-abort and overflow sequences (MEM_DEPTH overridden to 2).
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_last;
  logic        byte_ready;
  logic        we;
  logic [17:0] waddr;
  logic [31:0] wdata;
  logic [18:0] word_count;
  logic        busy, done, err, cpu_hold;

  int checks   = 0;
  int failures = 0;

  // flags = {byte_ready, busy, done, err, cpu_hold}
  localparam logic [4:0] F_IDLE  = 5'b00001;
  localparam logic [4:0] F_LOAD  = 5'b11001;
  localparam logic [4:0] F_FLUSH = 5'b01001;
  localparam logic [4:0] F_DONE  = 5'b00100;
  localparam logic [4:0] F_ERR   = 5'b00011;

  typedef struct {
    logic        st;
    logic        v;
    logic [7:0]  b;
    logic        l;
    logic        we;
    logic [17:0] wa;
    logic [31:0] wd;
    logic [18:0] wc;
    logic [4:0]  fl;
  } vec_t;

  imem_loader #(.MEM_WIDTH_LENGTH(32), .ADDR_WIDTH(18), .MEM_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_last(byte_last), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .word_count(word_count),
    .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic v, input logic [7:0] b, input logic l,
                              input logic e_we, input logic [17:0] wa, input logic [31:0] wd,
                              input logic [18:0] wc, input logic [4:0] fl);
    vec_t r;
    r.st = st; r.v = v; r.b = b; r.l = l;
    r.we = e_we; r.wa = wa; r.wd = wd; r.wc = wc; r.fl = fl;
    return r;
  endfunction

  task automatic chk(input string name, input logic e_we, input logic [17:0] wa,
                     input logic [31:0] wd, input logic [18:0] wc, input logic [4:0] fl);
    logic [4:0] act_fl;
    logic       ok;
    act_fl = {byte_ready, busy, done, err, cpu_hold};
    ok = (we === e_we) && (word_count === wc) && (act_fl === fl) &&
         (!e_we || ((waddr === wa) && (wdata === wd)));
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got we=%b waddr=%0h wdata=%08h wc=%0d flags=%b, want we=%b waddr=%0h wdata=%08h wc=%0d flags=%b",
               name, we, waddr, wdata, word_count, act_fl, e_we, wa, wd, wc, fl);
    end
  endtask

  task automatic step(input logic st, input logic v, input logic [7:0] b, input logic l);
    start = st; byte_valid = v; byte_in = b; byte_last = l;
    @(posedge clk);
    #1;
    start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; byte_last = 1'b0;
  endtask

  vec_t tbl[25];

  initial begin
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_in = 8'h00; byte_last = 1'b0;

    // nominal load
    tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[1]  = mk(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[2]  = mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[3]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[4]  = mk(1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 18'd0, 32'h00000513, 19'd1, F_LOAD);
    tbl[5]  = mk(1'b0, 1'b1, 8'h93, 1'b0, 1'b0, 18'd0, 32'h0, 19'd1, F_LOAD);
    tbl[6]  = mk(1'b0, 1'b1, 8'h05, 1'b0, 1'b0, 18'd0, 32'h0, 19'd1, F_LOAD);
    tbl[7]  = mk(1'b0, 1'b1, 8'h10, 1'b0, 1'b0, 18'd0, 32'h0, 19'd1, F_LOAD);
    tbl[8]  = mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 18'd1, 32'h00100593, 19'd2, F_FLUSH);
    tbl[9]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd2, F_DONE);
    // reload from DONE, partial word
    tbl[10] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[11] = mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[12] = mk(1'b0, 1'b1, 8'hBB, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[13] = mk(1'b0, 1'b1, 8'hCC, 1'b1, 1'b1, 18'd0, 32'h00CCBBAA, 19'd1, F_FLUSH);
    tbl[14] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd1, F_DONE);
    tbl[15] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    // backpressure gaps 1-0-0-1-1-0-1
    tbl[16] = mk(1'b0, 1'b1, 8'h11, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[17] = mk(1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[18] = mk(1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[19] = mk(1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[20] = mk(1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[21] = mk(1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    tbl[22] = mk(1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 18'd0, 32'h44332211, 19'd1, F_LOAD);
    // byte_last without byte_valid ignored; start inside LOAD ignored
    tbl[23] = mk(1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 18'd0, 32'h0, 19'd1, F_LOAD);
    tbl[24] = mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 18'd0, 32'h0, 19'd1, F_LOAD);

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 1'b0, 18'd0, 32'h0, 19'd0, F_IDLE);
    checks++;
    if ({waddr, wdata} !== 50'd0) begin
      failures++;
      $display("FAIL reset_wport: got waddr=%0h wdata=%08h, want 0/0", waddr, wdata);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      step(tbl[i].st, tbl[i].v, tbl[i].b, tbl[i].l);
      chk($sformatf("vec%0d", i), tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].wc, tbl[i].fl);
    end

    // reset mid-word after two accepted bytes
    step(1'b0, 1'b1, 8'h55, 1'b0);
    step(1'b0, 1'b1, 8'h66, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async", 1'b0, 18'd0, 32'h0, 19'd0, F_IDLE);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_restart", 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b1, 8'h03, 1'b0);
    step(1'b0, 1'b1, 8'h04, 1'b0);
    chk("rst_word0", 1'b1, 18'd0, 32'h04030201, 19'd1, F_LOAD);

    // overflow with MEM_DEPTH=2; start+valid in IDLE must not accept EE
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    chk("ovf_start", 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);
    for (int i = 0; i < 9; i++) begin
      logic        e_we;
      logic [18:0] e_wc;
      e_we = (i == 3) || (i == 7);
      e_wc = (i < 3) ? 19'd0 : ((i < 7) ? 19'd1 : 19'd2);
      step(1'b0, 1'b1, 8'(i + 1), 1'b0);
      chk($sformatf("ovf_b%0d", i), e_we, (i == 7) ? 18'd1 : 18'd0,
          (i == 7) ? 32'h08070605 : 32'h04030201, e_wc, (i == 8) ? F_ERR : F_LOAD);
    end
    step(1'b0, 1'b1, 8'h77, 1'b1);
    chk("err_hold", 1'b0, 18'd0, 32'h0, 19'd2, F_ERR);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("err_restart", 1'b0, 18'd0, 32'h0, 19'd0, F_LOAD);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
